// File: rtl/rx_crc_check_if.sv
// Byte handshake from the UART receiver into the receive-side CRC checker.
interface rx_crc_check_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/rx_crc_check.sv
// Modbus RTU receive CRC-16 checker: bit-serial CRC over each frame, one-cycle verdict on frame end.
// Optional slave-address filter enabled by defining RX_CRC_ADDR_FILTER_EN (adds SADDR and addr_drop).
module rx_crc_check #(
    parameter int unsigned MAX_LEN = 256
`ifdef RX_CRC_ADDR_FILTER_EN
    , parameter logic [7:0] SADDR = 8'h01
`endif
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    rx_crc_check_if.slave rx,
    input  logic          frame_end,
    output logic          crc_ok,
    output logic          crc_err,
    output logic [8:0]    frame_len,
    output logic [15:0]   crc_rcv,
    output logic [15:0]   crc_calc,
    output logic          busy
`ifdef RX_CRC_ADDR_FILTER_EN
    , output logic        addr_drop
`endif
);

    localparam int unsigned CRC_W  = 16;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [CRC_W-1:0] CRC_INIT  = 16'hFFFF;
    localparam logic [CRC_W-1:0] CRC_POLY  = 16'hA001;
    localparam logic [CNT_W-1:0] CNT_SAT   = 9'h1FF;
    localparam logic [CNT_W-1:0] CNT_MIN   = 9'd4;
    localparam logic [CNT_W:0]   MAX_LEN_W = (CNT_W+1)'(MAX_LEN);
    localparam logic [BIT_W-1:0] BIT_LAST  = 3'd7;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        BIT    = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CRC_W-1:0]   hist1_q, hist1_d;
    logic [CRC_W-1:0]   hist2_q, hist2_d;
    logic [CRC_W-1:0]   rcv_sh_q, rcv_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               busy_d;
    logic               ready_q, ready_d;
    logic               crc_ok_d, crc_err_d;
    logic [CNT_W-1:0]   frame_len_d;
    logic [CRC_W-1:0]   crc_rcv_d, crc_calc_d;
    logic [CRC_W-1:0]   crc_base;
    logic               accept;
    logic               pass;
    logic               drop_q, drop_d;
    logic               addr_drop_d;

    // One LSB-first step of the reflected Modbus polynomial.
    function automatic logic [CRC_W-1:0] crc_shift(input logic [CRC_W-1:0] c);
        return (c >> 1) ^ (c[0] ? CRC_POLY : '0);
    endfunction

    assign rx.rx_ready = ready_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        hist1_d     = hist1_q;
        hist2_d     = hist2_q;
        rcv_sh_d    = rcv_sh_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        busy_d      = busy;
        drop_d      = drop_q;
        crc_ok_d    = 1'b0;
        crc_err_d   = 1'b0;
        addr_drop_d = 1'b0;
        frame_len_d = frame_len;
        crc_rcv_d   = crc_rcv;
        crc_calc_d  = crc_calc;
        crc_base    = busy ? crc_q : CRC_INIT;
        pass        = 1'b0;
        accept      = (state_q == WAIT) && rx.rx_valid && ready_q;

        unique case (state_q)
            WAIT: begin
                if (accept) begin
                    hist2_d   = hist1_q;
                    hist1_d   = crc_base;
                    rcv_sh_d  = {rx.rx_data, rcv_sh_q[CRC_W-1:DATA_W]};
                    crc_d     = crc_base ^ {8'h00, rx.rx_data};
                    cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : CNT_W'(cnt_q + 9'd1);
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    // A frame end arriving with a byte closes the frame after that byte.
                    pend_d    = frame_end;
`ifdef RX_CRC_ADDR_FILTER_EN
                    if (!busy) begin
                        drop_d = (rx.rx_data != SADDR) && (rx.rx_data != 8'h00);
                    end
`endif
                    state_d   = BIT;
                end else if (frame_end && busy) begin
                    state_d = RESULT;
                end
            end
            BIT: begin
                crc_d     = crc_shift(crc_q);
                bit_cnt_d = BIT_W'(bit_cnt_q + 3'd1);
                if (frame_end) begin
                    pend_d = 1'b1;
                end
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = (pend_q || frame_end) ? RESULT : WAIT;
                end
            end
            RESULT: begin
                crc_d    = CRC_INIT;
                hist1_d  = CRC_INIT;
                hist2_d  = CRC_INIT;
                rcv_sh_d = '0;
                cnt_d    = '0;
                pend_d   = 1'b0;
                busy_d   = 1'b0;
                drop_d   = 1'b0;
                state_d  = WAIT;
            end
            default: state_d = WAIT;
        endcase

        // Verdict registers load on entry to RESULT so they are visible during that cycle.
        if (state_d == RESULT) begin
            pass        = (cnt_q >= CNT_MIN) && ({1'b0, cnt_q} <= MAX_LEN_W) && (crc_d == '0);
            frame_len_d = cnt_q;
            crc_rcv_d   = rcv_sh_q;
            crc_calc_d  = hist2_q;
            if (drop_q) begin
                addr_drop_d = 1'b1;
            end else begin
                crc_ok_d  = pass;
                crc_err_d = !pass;
            end
        end

        ready_d = (state_d == WAIT);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= WAIT;
            bit_cnt_q <= '0;
            crc_q     <= CRC_INIT;
            hist1_q   <= CRC_INIT;
            hist2_q   <= CRC_INIT;
            rcv_sh_q  <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            busy      <= 1'b0;
            drop_q    <= 1'b0;
            ready_q   <= 1'b1;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            frame_len <= '0;
            crc_rcv   <= '0;
            crc_calc  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            crc_q     <= crc_d;
            hist1_q   <= hist1_d;
            hist2_q   <= hist2_d;
            rcv_sh_q  <= rcv_sh_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            busy      <= busy_d;
            drop_q    <= drop_d;
            ready_q   <= ready_d;
            crc_ok    <= crc_ok_d;
            crc_err   <= crc_err_d;
            frame_len <= frame_len_d;
            crc_rcv   <= crc_rcv_d;
            crc_calc  <= crc_calc_d;
        end
    end

`ifdef RX_CRC_ADDR_FILTER_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_drop <= 1'b0;
        end else begin
            addr_drop <= addr_drop_d;
        end
    end
`else
    // Without the filter no frame is ever marked for dropping.
    logic unused_addr_drop;
    assign unused_addr_drop = addr_drop_d;
`endif

endmodule

// File: doc/rx_crc_check.md
Name: rx_crc_check

Overview:
- Receive-side CRC checker for the Modbus RTU slave; counterpart of the transmit CRC generator.
- Accepts frame bytes one at a time from the UART receiver over a valid/ready handshake.
- Runs CRC-16/Modbus over every byte, including the two trailing CRC bytes.
- On the frame-end strobe from the t3.5 silence timer, emits a one-cycle pass or fail verdict, with frame length, received CRC and calculated CRC for the frame decoder.

Parameters:
SADDR, 8'h01, slave address; used only when the optional feature is compiled in.
MAX_LEN, 256, maximum legal frame length in bytes (Modbus RTU ADU limit).

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous reset, active low
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid; held by upstream until accepted
rx_ready  output  1  checker can accept a byte
frame_end  input  1  one-cycle pulse: inter-frame silence detected
crc_ok  output  1  one-cycle pulse: frame passed the check
crc_err  output  1  one-cycle pulse: frame failed the check
frame_len  output  9  byte count of the last completed frame, including the CRC bytes
crc_rcv  output  16  {last byte, second-to-last byte} of the last frame
crc_calc  output  16  CRC over all bytes except the last two
busy  output  1  a frame is open (at least one byte accepted, no verdict yet)

Behaviour:
- Reset values: every output 0 except rx_ready = 1. Internal CRC register = 16'hFFFF, state = WAIT, byte count 0, pending flag 0.
- Reset mid-operation discards the open frame and returns to WAIT. No verdict is produced for the discarded frame.
- States: WAIT, BIT, RESULT.
- WAIT: rx_ready = 1. A byte is accepted when rx_valid && rx_ready.
  - If this is the first byte of a frame: CRC register starts from FFFF and busy rises.
  - Snapshot history: hist2 <= hist1, hist1 <= CRC value before this byte.
  - crc_rcv shifts as {rx_data, crc_rcv_shadow[15:8]}.
  - XOR rx_data into CRC[7:0]; increment the byte count, saturating at 511.
  - Go to BIT.
- BIT: rx_ready = 0. One bit per cycle for exactly 8 cycles: crc = (crc >> 1) ^ (lsb ? 16'hA001 : 0).
  - After the 8th cycle go to WAIT; if the pending flag is set, go to RESULT instead.
  - rx_ready is high again on the 9th cycle after acceptance.
- frame_end sampled in BIT sets the pending flag.
- frame_end sampled in WAIT with busy = 1: go to RESULT.
- frame_end with busy = 0: ignored, no pulse.
- frame_end and an accepted byte in the same WAIT cycle: the byte belongs to the current frame. The verdict follows after its 8 BIT cycles.
- RESULT, a single cycle:
  - crc_ok = (count >= 4) && (count <= MAX_LEN) && (crc == 16'h0000); crc_err is its complement.
  - frame_len, crc_rcv and crc_calc (= hist2) are updated in the same cycle. They are held until the next RESULT.
  - Clears busy, the count and the pending flag; CRC register reloads FFFF. Next state is WAIT.
  - rx_ready = 0 during RESULT.
- Short frames (count 1..3) give crc_err; crc_calc = hist2, which is FFFF if fewer than 2 bytes were received.
- Overflow (count > MAX_LEN): bytes are still accepted and the CRC still runs; the verdict is crc_err.
- crc_ok and crc_err are never both high and never high outside RESULT.

Optional Feature:
- Macro: RX_CRC_ADDR_FILTER_EN.
- When defined:
  - The first byte of each frame is compared with SADDR and with 8'h00 (broadcast).
  - A mismatch sets a drop flag. At RESULT, a dropped frame gives neither crc_ok nor crc_err.
  - Extra output addr_drop (1 bit) pulses instead; frame_len and the CRC outputs still update.
- When undefined: no address check, no addr_drop port; every frame gets crc_ok or crc_err.

Test Plan:
1. Feed 01 03 00 00 00 0A C5 CD, then frame_end -> crc_ok for 1 cycle, crc_err = 0, frame_len = 8, crc_rcv = 16'hCDC5, crc_calc = 16'hCDC5.
2. Same frame with last byte CE -> crc_err pulse, crc_rcv = 16'hCEC5, crc_calc = 16'hCDC5, frame_len = 8.
3. Hold rx_valid high continuously -> exactly one byte accepted per 9 cycles. rx_ready low during BIT. Pulse frame_end in the middle of BIT of the last byte -> verdict arrives the cycle after the 8th bit, same result as test 1.
4. Two bytes 01 03 then frame_end -> crc_err, frame_len = 2. frame_end with no bytes -> no pulse.
5. 257 bytes with valid CRC -> crc_err, frame_len = 257. Reset asserted mid-frame then frame_end -> no pulse, all outputs 0, rx_ready = 1.
6. With RX_CRC_ADDR_FILTER_EN, SADDR = 01: frame 02 03 00 00 00 0A + correct CRC -> addr_drop pulse, no crc_ok/crc_err. Frame from test 1 -> crc_ok.
